// File: rtl/carfield_addr_router_pkg.sv
// Shared types, address-map rule record and match helper for the Carfield request router.
package carfield_addr_router_pkg;

    localparam int unsigned NumRules       = 8;
    localparam int unsigned AddrWidth      = 64;
    localparam int unsigned DataWidth      = 64;
    localparam int unsigned MaxOutstanding = 4;

    localparam logic [DataWidth-1:0] ErrData = 64'hBADCAB1E_BADCAB1E;

    localparam int unsigned IdxWidth = $clog2(NumRules + 1);
    localparam int unsigned SelWidth = $clog2(NumRules);
    localparam int unsigned CntWidth = $clog2(MaxOutstanding + 1);

    typedef logic [IdxWidth-1:0] tgt_idx_t;
    typedef logic [CntWidth-1:0] cnt_t;

    // One past the last real port: selects the internal error responder.
    localparam tgt_idx_t ErrIdx = tgt_idx_t'(NumRules);

    typedef struct packed {
        logic [AddrWidth-1:0] base;
        logic [AddrWidth-1:0] size;
        logic                 en;
    } rule_t;

    // Upper bound is formed one bit wider so a region ending at the top of memory cannot wrap.
    function automatic logic rule_match(input rule_t rule, input logic [AddrWidth-1:0] addr);
        logic [AddrWidth:0] limit;
        limit = {1'b0, rule.base} + {1'b0, rule.size};
        return rule.en && (rule.size != '0) && (addr >= rule.base) && ({1'b0, addr} < limit);
    endfunction

endpackage

// File: rtl/carfield_addr_decode.sv
// Priority address decoder: lowest-index enabled rule wins, no match selects ErrIdx.
// Purely combinational, no backpressure.
module carfield_addr_decode
    import carfield_addr_router_pkg::*;
(
    input  logic [NumRules-1:0][AddrWidth-1:0] rule_base_i,
    input  logic [NumRules-1:0][AddrWidth-1:0] rule_size_i,
    input  logic [NumRules-1:0]                rule_en_i,
    input  logic [AddrWidth-1:0]               addr_i,
    output tgt_idx_t                           idx_o,
    output logic                               err_o
);

    rule_t rules [NumRules];

    for (genvar g = 0; g < NumRules; g++) begin : g_rule
        assign rules[g] = '{base: rule_base_i[g], size: rule_size_i[g], en: rule_en_i[g]};
    end

    // Scanning from the top down lets the lowest matching index overwrite the others.
    always_comb begin
        idx_o = ErrIdx;
        for (int k = NumRules - 1; k >= 0; k--) begin
            if (rule_match(rules[k], addr_i)) begin
                idx_o = tgt_idx_t'(k);
            end
        end
        err_o = (idx_o == ErrIdx);
    end

endmodule

// File: rtl/carfield_addr_router.sv
// In-order request router: grant passes through from the selected target in the same cycle,
// error responses return one cycle after grant; host is stalled on target switch or full tracker.
module carfield_addr_router
    import carfield_addr_router_pkg::*;
(
    input  logic                                clk_i,
    input  logic                                rst_ni,
    input  logic [NumRules-1:0][AddrWidth-1:0]  rule_base_i,
    input  logic [NumRules-1:0][AddrWidth-1:0]  rule_size_i,
    input  logic [NumRules-1:0]                 rule_en_i,
    input  logic                                req_i,
    output logic                                gnt_o,
    input  logic [AddrWidth-1:0]                addr_i,
    input  logic                                we_i,
    input  logic [DataWidth-1:0]                wdata_i,
    input  logic [DataWidth/8-1:0]              be_i,
    output logic                                rvalid_o,
    output logic [DataWidth-1:0]                rdata_o,
    output logic                                err_o,
    output logic [NumRules-1:0]                 tgt_req_o,
    input  logic [NumRules-1:0]                 tgt_gnt_i,
    output logic [AddrWidth-1:0]                tgt_addr_o,
    output logic                                tgt_we_o,
    output logic [DataWidth-1:0]                tgt_wdata_o,
    output logic [DataWidth/8-1:0]              tgt_be_o,
    input  logic [NumRules-1:0]                 tgt_rvalid_i,
    input  logic [NumRules-1:0][DataWidth-1:0]  tgt_rdata_i,
    input  logic [NumRules-1:0]                 tgt_err_i
);

    localparam cnt_t CntMax = cnt_t'(MaxOutstanding);

    tgt_idx_t                dec_idx;
    logic                    dec_err;
    logic [SelWidth-1:0]     dec_sel;
    logic [SelWidth-1:0]     tgt_sel;
    logic                    can_issue;
    logic                    rsp_vld;

    cnt_t                    cnt_q, cnt_d;
    tgt_idx_t                tgt_q, tgt_d;
    logic [MaxOutstanding-1:0] err_pend_q, err_pend_d;

    carfield_addr_decode u_decode (
        .rule_base_i (rule_base_i),
        .rule_size_i (rule_size_i),
        .rule_en_i   (rule_en_i),
        .addr_i      (addr_i),
        .idx_o       (dec_idx),
        .err_o       (dec_err)
    );

    assign tgt_addr_o  = addr_i;
    assign tgt_we_o    = we_i;
    assign tgt_wdata_o = wdata_i;
    assign tgt_be_o    = be_i;

    assign dec_sel = dec_idx[SelWidth-1:0];
    assign tgt_sel = tgt_q[SelWidth-1:0];

    // Responses carry no ID, so a new target is only opened once the old one has drained.
    assign can_issue = (cnt_q < CntMax) && ((cnt_q == '0) || (dec_idx == tgt_q));

    always_comb begin
        tgt_req_o = '0;
        gnt_o     = 1'b0;
        if (req_i && can_issue) begin
            if (dec_err) begin
                gnt_o = 1'b1;
            end else begin
                tgt_req_o[dec_sel] = 1'b1;
                gnt_o              = tgt_gnt_i[dec_sel];
            end
        end
    end

    always_comb begin
        rsp_vld = 1'b0;
        rdata_o = '0;
        err_o   = 1'b0;
        if (cnt_q != '0) begin
            rsp_vld = (tgt_q == ErrIdx) ? err_pend_q[0] : tgt_rvalid_i[tgt_sel];
        end
        if (rsp_vld) begin
            if (tgt_q == ErrIdx) begin
                rdata_o = ErrData;
                err_o   = 1'b1;
            end else begin
                rdata_o = tgt_rdata_i[tgt_sel];
                err_o   = tgt_err_i[tgt_sel];
            end
        end
    end

    assign rvalid_o = rsp_vld;

    // Bit 0 of err_pend_q is the error response owed this cycle; each error grant sets it for the next.
    always_comb begin
        cnt_d = cnt_q;
        if (gnt_o && !rsp_vld) begin
            cnt_d = cnt_q + cnt_t'(1);
        end else if (!gnt_o && rsp_vld) begin
            cnt_d = cnt_q - cnt_t'(1);
        end
        tgt_d      = gnt_o ? dec_idx : tgt_q;
        err_pend_d = {1'b0, err_pend_q[MaxOutstanding-1:1]};
        if (gnt_o && dec_err) begin
            err_pend_d[0] = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q      <= '0;
            tgt_q      <= '0;
            err_pend_q <= '0;
        end else begin
            cnt_q      <= cnt_d;
            tgt_q      <= tgt_d;
            err_pend_q <= err_pend_d;
        end
    end

endmodule

// File: tb/tb_carfield_addr_router.sv
// Randomized bench for carfield_addr_router: host/target agents plus a queue-based in-order response model.
module tb_carfield_addr_router;

    localparam logic [63:0] ERR_DATA = 64'hBADC_AB1E_BADC_AB1E;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [7:0][63:0]  rule_base, rule_size;
    logic [7:0]        rule_en;
    logic              req_i, gnt_o, we_i;
    logic [63:0]       addr_i, wdata_i;
    logic [7:0]        be_i;
    logic              rvalid_o, err_o;
    logic [63:0]       rdata_o;
    logic [7:0]        tgt_req_o, tgt_gnt_i;
    logic [63:0]       tgt_addr_o, tgt_wdata_o;
    logic              tgt_we_o;
    logic [7:0]        tgt_be_o;
    logic [7:0]        tgt_rvalid_i, tgt_err_i;
    logic [7:0][63:0]  tgt_rdata_i;

    always #5 clk = ~clk;

    carfield_addr_router dut (
        .clk_i(clk), .rst_ni(rst_n),
        .rule_base_i(rule_base), .rule_size_i(rule_size), .rule_en_i(rule_en),
        .req_i(req_i), .gnt_o(gnt_o), .addr_i(addr_i), .we_i(we_i), .wdata_i(wdata_i), .be_i(be_i),
        .rvalid_o(rvalid_o), .rdata_o(rdata_o), .err_o(err_o),
        .tgt_req_o(tgt_req_o), .tgt_gnt_i(tgt_gnt_i), .tgt_addr_o(tgt_addr_o), .tgt_we_o(tgt_we_o),
        .tgt_wdata_o(tgt_wdata_o), .tgt_be_o(tgt_be_o), .tgt_rvalid_i(tgt_rvalid_i),
        .tgt_rdata_i(tgt_rdata_i), .tgt_err_i(tgt_err_i)
    );

    typedef struct packed { logic err; logic [63:0] data; } rsp_t;
    typedef struct packed { logic [63:0] addr; logic we; } hreq_t;

    hreq_t host_q[$];
    rsp_t  exp_q[$];
    rsp_t  pend[8][$];
    int    cur_tgt = 0;
    bit    err_due = 0;
    bit    host_acc = 0;
    int    gnt_pct = 100, rsp_pct = 100, junk_pct = 0;
    int    n_chk = 0, n_fail = 0, cyc = 0;
    int    grants = 0, rsps = 0, rv_seen = 0, req2_seen = 0;
    int    last_gnt_cyc = 0, last_rsp_cyc = 0;
    logic [7:0] last_gnt_req = '0;
    rsp_t  last_rsp = '0;

    task automatic chk(input bit ok, input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s: got 0x%h required 0x%h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Address map semantics: first enabled, non-empty region containing the address.
    function automatic int ref_decode(input logic [63:0] a);
        for (int k = 0; k < 8; k++) begin
            if (rule_en[k] && rule_size[k] != 64'd0 && a >= rule_base[k] && (a - rule_base[k]) < rule_size[k])
                return k;
        end
        return 8;
    endfunction

    function automatic logic [63:0] mkdata(input int k, input logic [63:0] a);
        return a ^ {8'(k), 56'h0} ^ 64'h0123_4567_89AB_CDEF;
    endfunction

    always @(negedge clk) begin
        int         idx;
        bit         allowed, egnt, erv;
        logic [7:0] ereq;
        rsp_t       r;
        cyc++;
        if (rvalid_o) rv_seen++;
        if (!rst_n) begin
            chk(tgt_req_o == 8'h0, "rst_tgt_req", 64'(tgt_req_o), 64'h0);
            chk(gnt_o == 1'b0, "rst_gnt", 64'(gnt_o), 64'h0);
            chk(rvalid_o == 1'b0, "rst_rvalid", 64'(rvalid_o), 64'h0);
            chk(err_o == 1'b0, "rst_err", 64'(err_o), 64'h0);
            chk(rdata_o == 64'h0, "rst_rdata", rdata_o, 64'h0);
            exp_q.delete();
            err_due  = 0;
            host_acc = 0;
        end else begin
            idx     = ref_decode(addr_i);
            allowed = exp_q.size() < 4 && (exp_q.size() == 0 || idx == cur_tgt);
            ereq    = (req_i && allowed && idx < 8) ? (8'b1 << idx) : 8'h0;
            egnt    = req_i && allowed && ((idx == 8) ? 1'b1 : tgt_gnt_i[idx]);
            erv     = exp_q.size() > 0 && ((cur_tgt == 8) ? err_due : tgt_rvalid_i[cur_tgt]);
            chk(tgt_req_o === ereq, "tgt_req", 64'(tgt_req_o), 64'(ereq));
            chk(gnt_o === egnt, "gnt", 64'(gnt_o), 64'(egnt));
            chk(rvalid_o === erv, "rvalid", 64'(rvalid_o), 64'(erv));
            if (req_i)
                chk(tgt_addr_o === addr_i && tgt_we_o === we_i && tgt_wdata_o === wdata_i && tgt_be_o === be_i,
                    "broadcast", tgt_addr_o, addr_i);
            if (erv) begin
                r = exp_q.pop_front();
                chk(rdata_o === r.data, "rdata", rdata_o, r.data);
                chk(err_o === r.err, "rsp_err", 64'(err_o), 64'(r.err));
                last_rsp     = '{err: err_o, data: rdata_o};
                last_rsp_cyc = cyc;
                rsps++;
            end
            if (egnt) begin
                if (idx == 8) exp_q.push_back('{err: 1'b1, data: ERR_DATA});
                else          exp_q.push_back('{err: addr_i[2], data: mkdata(idx, addr_i)});
                cur_tgt      = idx;
                last_gnt_req = tgt_req_o;
                last_gnt_cyc = cyc;
                grants++;
            end
            err_due = egnt && idx == 8;
            if (tgt_req_o[2]) req2_seen++;
            host_acc = req_i && gnt_o;
        end
        for (int k = 0; k < 8; k++)
            if (tgt_rvalid_i[k] && pend[k].size() > 0) void'(pend[k].pop_front());
        for (int k = 0; k < 8; k++)
            if (rst_n && tgt_req_o[k] && tgt_gnt_i[k])
                pend[k].push_back('{err: tgt_addr_o[2], data: mkdata(k, tgt_addr_o)});
    end

    // Host agent: holds each request until granted; drops it immediately on reset.
    initial begin
        req_i = 0; addr_i = '0; we_i = 0; wdata_i = '0; be_i = '0;
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                req_i = 0;
            end else begin
                #1;
                if (req_i && host_acc) begin
                    void'(host_q.pop_front());
                    req_i = 0;
                end
                if (!req_i && host_q.size() > 0 && $urandom_range(0, 3) != 0) begin
                    addr_i  = host_q[0].addr;
                    we_i    = host_q[0].we;
                    wdata_i = {$urandom, $urandom};
                    be_i    = 8'($urandom);
                    req_i   = 1;
                end
            end
        end
    end

    // Target agents: random grants, in-order responses, unsolicited rvalid from idle targets.
    initial begin
        tgt_gnt_i = '0; tgt_rvalid_i = '0; tgt_rdata_i = '0; tgt_err_i = '0;
        forever begin
            @(posedge clk);
            #1;
            for (int k = 0; k < 8; k++) begin
                tgt_gnt_i[k] = ($urandom_range(0, 99) < gnt_pct);
                if (pend[k].size() > 0) begin
                    tgt_rvalid_i[k] = ($urandom_range(0, 99) < rsp_pct);
                    tgt_rdata_i[k]  = pend[k][0].data;
                    tgt_err_i[k]    = pend[k][0].err;
                end else begin
                    tgt_rvalid_i[k] = ($urandom_range(0, 99) < junk_pct);
                    tgt_rdata_i[k]  = {$urandom, $urandom};
                    tgt_err_i[k]    = 1'($urandom);
                end
            end
        end
    end

    task automatic send(input logic [63:0] a, input logic we = 1'b0);
        host_q.push_back('{addr: a, we: we});
    endtask

    task automatic wait_idle(input string nm, input int budget);
        int t = 0;
        while ((host_q.size() > 0 || req_i || exp_q.size() > 0) && t < budget) begin
            @(posedge clk);
            t++;
        end
        chk(t < budget, {nm, "_timeout"}, 64'(t), 64'(budget));
        repeat (2) @(posedge clk);
    endtask

    function automatic logic [63:0] gen_addr();
        logic [63:0] edges [10];
        edges = '{64'h77FF_FFF8, 64'h781F_FFF8, 64'h7820_0000, 64'h783F_FFF8, 64'h7840_0000,
                  64'h3FFF_FFF8, 64'h4000_0FF8, 64'h4000_1000, 64'hFFFF_FFFF_FFFF_EFF8, 64'h3000_0000};
        case ($urandom_range(0, 6))
            0, 6: return 64'h7800_0000 + 64'($urandom_range(0, 32'h3FFFF)) * 8;
            1:    return 64'h7820_0000 + 64'($urandom_range(0, 32'h3FFFF)) * 8;
            2:    return 64'h4000_0000 + 64'($urandom_range(0, 32'h1FF)) * 8;
            3:    return edges[$urandom_range(0, 9)];
            4:    return {$urandom, $urandom};
            default: return 64'hFFFF_FFFF_FFFF_F000 + 64'($urandom_range(0, 32'h1FF)) * 8;
        endcase
    endfunction

    initial begin
        int g0, rv0, t;
        rst_n = 0;
        rule_base = '0; rule_size = '0; rule_en = '0;
        rule_base[0] = 64'h7800_0000; rule_size[0] = 64'h20_0000;
        rule_base[1] = 64'h7820_0000; rule_size[1] = 64'h20_0000;
        rule_base[2] = 64'h4000_0000; rule_size[2] = 64'h1000;
        rule_base[3] = 64'h7800_0000; rule_size[3] = 64'h20_0000;
        rule_base[5] = 64'h3000_0000; rule_size[5] = 64'h0;
        rule_base[7] = 64'hFFFF_FFFF_FFFF_F000; rule_size[7] = 64'h1000;
        rule_en = 8'b1010_1111;
        repeat (3) @(posedge clk);
        #3 rst_n = 1;

        send(64'h781F_FFF8); wait_idle("rd0", 100);
        chk(last_gnt_req == 8'h01, "rd0_sel", 64'(last_gnt_req), 64'h01);
        chk(last_rsp.err == 1'b0, "rd0_err", 64'(last_rsp.err), 64'h0);
        send(64'h7820_0000); wait_idle("rd1", 100);
        chk(last_gnt_req == 8'h02, "rd1_sel", 64'(last_gnt_req), 64'h02);
        chk(last_rsp.err == 1'b0, "rd1_err", 64'(last_rsp.err), 64'h0);
        send(64'h3000_0000); wait_idle("unmapped", 100);
        chk(last_gnt_req == 8'h00, "unmapped_sel", 64'(last_gnt_req), 64'h0);
        chk(last_rsp.data == 64'hBADCAB1EBADCAB1E, "unmapped_data", last_rsp.data, 64'hBADCAB1EBADCAB1E);
        chk(last_rsp.err == 1'b1, "unmapped_err", 64'(last_rsp.err), 64'h1);
        chk(last_rsp_cyc - last_gnt_cyc == 1, "unmapped_latency", 64'(last_rsp_cyc - last_gnt_cyc), 64'h1);
        send(64'hFFFF_FFFF_FFFF_FFF8); wait_idle("top", 100);
        chk(last_gnt_req == 8'h80, "top_no_wrap", 64'(last_gnt_req), 64'h80);
        send(64'h4000_1000); wait_idle("r2_end", 100);
        chk(last_rsp.err == 1'b1, "r2_end_err", 64'(last_rsp.err), 64'h1);
        send(64'h4000_0FF8); wait_idle("r2_last", 100);
        chk(last_gnt_req == 8'h04, "r2_last_sel", 64'(last_gnt_req), 64'h04);
        rule_en[2] = 1'b0;
        send(64'h4000_0000); wait_idle("r2_dis", 100);
        chk(last_rsp.err == 1'b1 && last_gnt_req == 8'h00, "r2_dis_err", 64'(last_gnt_req), 64'h0);
        rule_en[2] = 1'b1;
        send(64'h7800_0000); wait_idle("overlap", 100);
        chk(last_gnt_req == 8'h01, "overlap_lowest", 64'(last_gnt_req), 64'h01);
        g0 = rsps;
        for (int i = 0; i < 3; i++) send(64'h1000_0000 + 64'(i) * 8);
        wait_idle("err_b2b", 100);
        chk(rsps - g0 == 3, "err_b2b_count", 64'(rsps - g0), 64'h3);

        rsp_pct = 0; g0 = grants;
        for (int i = 0; i < 5; i++) send(64'h7800_0100 + 64'(i) * 8);
        repeat (20) @(posedge clk);
        chk(grants - g0 == 4, "max_out_stall", 64'(grants - g0), 64'h4);
        chk(host_q.size() == 1, "max_out_held", 64'(host_q.size()), 64'h1);
        rsp_pct = 100; wait_idle("max_out", 200);
        chk(grants - g0 == 5, "max_out_resume", 64'(grants - g0), 64'h5);

        rsp_pct = 0; g0 = grants; req2_seen = 0;
        send(64'h7800_0200); send(64'h7800_0208); send(64'h4000_0010);
        repeat (20) @(posedge clk);
        chk(req2_seen == 0, "switch_blocked", 64'(req2_seen), 64'h0);
        chk(grants - g0 == 2, "switch_first", 64'(grants - g0), 64'h2);
        rsp_pct = 100; wait_idle("switch", 200);
        chk(grants - g0 == 3 && last_gnt_req == 8'h04, "switch_after_drain", 64'(last_gnt_req), 64'h04);

        rsp_pct = 0; g0 = grants;
        send(64'h7820_0010); send(64'h7820_0018);
        t = 0;
        while (grants - g0 < 2 && t < 50) begin @(posedge clk); t++; end
        chk(t < 50, "rst_setup_timeout", 64'(t), 64'd50);
        @(posedge clk); #3 rst_n = 0;
        repeat (2) @(posedge clk);
        #3 rst_n = 1;
        rv0 = rv_seen; rsp_pct = 100; t = 0;
        while (pend[1].size() > 0 && t < 50) begin @(posedge clk); t++; end
        repeat (3) @(posedge clk);
        chk(t < 50, "stale_drain_timeout", 64'(t), 64'd50);
        chk(rv_seen == rv0, "stale_rvalid_ignored", 64'(rv_seen - rv0), 64'h0);
        send(64'h7820_0020); wait_idle("post_rst", 100);
        chk(last_gnt_req == 8'h02 && grants - g0 == 3, "post_rst_issue", 64'(last_gnt_req), 64'h02);

        junk_pct = 20;
        for (int b = 0; b < 12; b++) begin
            gnt_pct    = $urandom_range(30, 100);
            rsp_pct    = $urandom_range(20, 100);
            rule_en[2] = ($urandom_range(0, 3) != 0);
            for (int i = 0; i < 50; i++) send(gen_addr(), 1'($urandom));
            wait_idle("random", 4000);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: got no end of test, required finish before %0d cycles", 90000);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail + 1);
        $fatal(1);
    end

endmodule

// File: doc/carfield_addr_router.md
Name: carfield_addr_router

Overview:
- Request-level address router between the host memory-request port and the Carfield islands (L2 ports, mailbox, peripherals, Spatz cluster).
- Decodes each request against the platform address map and forwards it to exactly one target port.
- Answers unmapped or disabled addresses with an error response from an internal error responder.
- Tracks outstanding transactions so responses return in order without response IDs.

Parameters:
- NumRules, 8: number of address rules; each rule maps to one target port.
- AddrWidth, 64: address width; matches the doub_bt address type.
- DataWidth, 64: data width.
- MaxOutstanding, 4: maximum number of in-flight requests.
- ErrData, 64'hBADCAB1E_BADCAB1E: read data returned with an error response.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  asynchronous active-low reset.
- rule_base_i  in  NumRules x AddrWidth  region base address per rule.
- rule_size_i  in  NumRules x AddrWidth  region size in bytes per rule.
- rule_en_i  in  NumRules  rule enable (the *Enable flags).
- req_i  in  1  host request valid.
- gnt_o  out  1  host request accepted.
- addr_i  in  AddrWidth  request address.
- we_i  in  1  write enable.
- wdata_i  in  DataWidth  write data.
- be_i  in  DataWidth/8  byte enables.
- rvalid_o  out  1  response valid.
- rdata_o  out  DataWidth  response data.
- err_o  out  1  response error.
- tgt_req_o  out  NumRules  per-target request.
- tgt_gnt_i  in  NumRules  per-target grant.
- tgt_addr_o, tgt_we_o, tgt_wdata_o, tgt_be_o  out  shared  copies of addr_i, we_i, wdata_i, be_i, broadcast to all targets.
- tgt_rvalid_i  in  NumRules  per-target response valid.
- tgt_rdata_i  in  NumRules x DataWidth  per-target response data.
- tgt_err_i  in  NumRules  per-target response error.

Behaviour:
- Decode is combinational.
  - Rule k matches when rule_en_i[k] is set, size is non-zero, and base <= addr < base+size.
  - The upper bound is computed in AddrWidth+1 bits, so there is no wrap.
  - When rules overlap, the lowest matching index wins.
  - No match selects the error target, ErrIdx = NumRules.
- State:
  - cnt_q: outstanding count, range 0..MaxOutstanding.
  - tgt_q: target of the in-flight requests, range 0..NumRules.
  - err_pend_q: shift register of pending error responses, depth MaxOutstanding.
- Issue rule: a request may issue only when both hold:
  - cnt_q < MaxOutstanding;
  - cnt_q == 0, or the decoded target == tgt_q.
- When blocked: tgt_req_o is all-zero and gnt_o=0; req_i is held by the host.
- Mapped issue:
  - tgt_req_o[idx] = req_i.
  - gnt_o = tgt_gnt_i[idx], combinational pass-through.
  - On the grant, tgt_q <= idx.
- Error issue:
  - gnt_o = 1 in the same cycle; no tgt_req_o bit is asserted.
  - Response comes exactly 1 cycle later: rvalid_o=1, err_o=1, rdata_o=ErrData.
  - Error requests occupy the outstanding counter like mapped ones, so back-to-back error requests yield one response per cycle.
- Response path:
  - rvalid_o = tgt_rvalid_i[tgt_q] when cnt_q > 0.
  - rdata_o and err_o are muxed from tgt_q.
  - rvalid from any target other than tgt_q is ignored.
  - rvalid while cnt_q == 0 is ignored, which covers stale responses after a reset.
- Counter:
  - +1 on a grant, -1 on a response.
  - Grant and response in the same cycle leave it unchanged.
  - It never exceeds MaxOutstanding and never underflows.
- Reset values:
  - cnt_q=0, tgt_q=0, err_pend_q=0.
  - gnt_o=0, rvalid_o=0, err_o=0, rdata_o=0, tgt_req_o=0.
  - Mid-operation reset drops all in-flight bookkeeping.
- Target switch: the router drains to cnt_q == 0 before accepting a request to a different target.
- Host protocol: req_i and the request fields are held stable until gnt_o; the router does not check this.

Decomposition:
- Package carfield_addr_router_pkg:
  - rule_t struct: base, size, en.
  - ErrIdx localparam.
  - tgt_idx_t typedef of width clog2(NumRules+1).
  - Helper function rule_match().
- Sub-module carfield_addr_decode: combinational rule-to-index priority decoder with error flag.
- The top module holds the counter, the target register, the error responder and the muxes.

Test Plan:
- Map rule0=0x78000000/0x200000, rule1=0x78200000/0x200000, rule2=0x40000000/0x1000. Read 0x781FFFF8 -> tgt_req_o=3'b001. Read 0x78200000 -> tgt_req_o=3'b010. Each response returns with err_o=0.
- Read 0x30000000 (unmapped) -> gnt_o=1 the same cycle; one cycle later rvalid_o=1, err_o=1, rdata_o=0xBADCAB1EBADCAB1E; no tgt_req_o asserted.
- Four requests to rule0 with responses withheld -> 5th request to rule0 stalls (gnt_o=0) until one rvalid arrives, then is granted.
- Two requests outstanding to rule0, then a request to rule2 -> no tgt_req_o[2] until both rule0 responses return; then rule2 is issued and ordering is preserved.
- rule_en_i[2]=0, access 0x40000000 -> error response. Overlapping rule3 = rule0 range -> rule0 is selected.
- Assert rst_ni low with 2 requests outstanding, then drive a late tgt_rvalid_i after reset -> rvalid_o stays 0, cnt_q=0, and the next request issues normally.
